// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM: port A pushes, port B pops.
// Holds the pointers, occupancy and status flags; the storage lives in the RAM.
module ram_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AFULL_LVL  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  ram_we_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_din_a,
   output logic                  ram_we_b,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   output logic [DATA_WIDTH-1:0] ram_din_b,
   input  logic [DATA_WIDTH-1:0] ram_dout_b
);

   localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AFULL_V = AFULL_LVL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE_V   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // Extra MSB on each pointer is the wrap bit, so full and empty stay distinct.
   logic [ADDR_WIDTH:0] wptr, rptr;
   logic                pop_ok, push_ok;

   assign count       = wptr - rptr;
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_V);
   assign almost_full = (count >= AFULL_V);

   // A push into a full FIFO is fine when a pop frees the slot in the same cycle.
   assign pop_ok  = rd_en & ~empty;
   assign push_ok = wr_en & (~full | pop_ok);

   assign ram_we_a   = push_ok;
   assign ram_addr_a = wptr[ADDR_WIDTH-1:0];
   assign ram_din_a  = wr_data;
   assign ram_we_b   = 1'b0;
   assign ram_addr_b = rptr[ADDR_WIDTH-1:0];
   assign ram_din_b  = '0;
   assign rd_data    = ram_dout_b;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + ONE_V;
         if (pop_ok)  rptr <= rptr + ONE_V;
         // RAM output is registered, so the popped word shows up one cycle later.
         rd_valid  <= pop_ok;
         overflow  <= overflow  | (wr_en & ~push_ok);
         underflow <= underflow | (rd_en & empty);
      end
   end

endmodule
